// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//
// Purpose:
//   Write-port scheduler and load scoreboard for a 32x32 register file
//   (x0 hardwired to zero, one write port, same-cycle write-to-read forwarding).
//   The ALU writeback stage and the load unit share the write port. The ALU
//   always wins. A load response that collides with an ALU write is parked in
//   a one-entry hold buffer. Outstanding load destinations are tracked so
//   decode can be stalled on RAW/WAW hazards.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   alu_valid/rd/data ALU writeback request (no backpressure)
//   ld_issue/_rd      load issued by decode; ld_issue_ready = tag FIFO not full
//   ld_resp_valid/data load data returning in issue order; ld_resp_ready = hold empty
//   dec_rs1/rs2/rd/rd_valid  decode operands checked for hazards
//   stall             decode hazard stall (combinational)
//   rf_write/addr/wdata register file write port
//   err               sticky protocol error
//
// Handshake semantics: a transfer happens on a cycle where both valid and
// ready are high. Ready never depends on valid in the same cycle. Both readies
// are low while rst is asserted. A valid seen while ready is low is not a
// transfer. The only exception is ld_issue against a full FIFO: that issue is
// dropped and flagged on err.
module regfile_wb_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    output logic        ld_issue_ready,
    input  logic        ld_resp_valid,
    input  logic [31:0] ld_resp_data,
    output logic        ld_resp_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rd_valid,
    output logic        stall,
    output logic        rf_write,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:1]      pending;
    logic [4:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             hold_valid;
    logic [4:0]       hold_rd;
    logic [31:0]      hold_data;
    logic             err_q;
    logic [4:0]       last_addr;
    logic [31:0]      last_data;

    logic        fifo_full;
    logic        fifo_empty;
    logic        issue_acc;
    logic        resp_acc;
    logic        resp_pop;
    logic [4:0]  head_rd;
    logic        drive;      // write port driven this cycle (updates last_*)
    logic        ld_done;    // a load's data is on the write port
    logic [4:0]  done_rd;
    logic [31:0] pend_full;  // pending with bit 0 tied low so rd can index directly
    logic [31:0] pend_nxt;
    logic [31:0] live;       // pending and not being forwarded this cycle

    assign fifo_full      = (count == CNT_W'(DEPTH));
    assign fifo_empty     = (count == '0);
    assign ld_issue_ready = !rst && !fifo_full;
    assign ld_resp_ready  = !rst && !hold_valid;
    assign issue_acc      = ld_issue && ld_issue_ready;
    assign resp_acc       = ld_resp_valid && ld_resp_ready;
    assign resp_pop       = resp_acc && !fifo_empty;
    assign head_rd        = fifo_mem[rd_ptr];
    assign pend_full      = {pending, 1'b0};
    assign err            = err_q;

    // Write-port arbitration: ALU, then held load, then a direct load response.
    always_comb begin
        rf_write = 1'b0;
        rf_addr  = last_addr;
        rf_wdata = last_data;
        drive    = 1'b0;
        ld_done  = 1'b0;
        done_rd  = head_rd;
        if (alu_valid) begin
            drive    = 1'b1;
            rf_write = (alu_rd != 5'd0);
            rf_addr  = alu_rd;
            rf_wdata = alu_data;
        end else if (hold_valid) begin
            drive    = 1'b1;
            ld_done  = 1'b1;
            done_rd  = hold_rd;
            rf_write = (hold_rd != 5'd0);
            rf_addr  = hold_rd;
            rf_wdata = hold_data;
        end else if (resp_pop) begin
            drive    = 1'b1;
            ld_done  = 1'b1;
            rf_write = (head_rd != 5'd0);
            rf_addr  = head_rd;
            rf_wdata = ld_resp_data;
        end
        if (rst) begin
            rf_write = 1'b0;
            rf_addr  = 5'd0;
            rf_wdata = 32'd0;
        end
    end

    // A register being written this cycle is forwarded by the register
    // file, so it no longer blocks decode.
    always_comb begin
        live = pend_full;
        if (rf_write) live = pend_full & ~(32'd1 << rf_addr);
        stall = !rst && (live[dec_rs1] || live[dec_rs2] || (dec_rd_valid && live[dec_rd]));
    end

    // Clear on completion first, then set on issue, so a same-cycle
    // issue to the same rd leaves the bit set.
    always_comb begin
        pend_nxt = pend_full;
        if (ld_done && done_rd != 5'd0) pend_nxt[done_rd] = 1'b0;
        if (issue_acc && ld_issue_rd != 5'd0) pend_nxt[ld_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (issue_acc) fifo_mem[wr_ptr] <= ld_issue_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_valid <= 1'b0;
            hold_rd    <= 5'd0;
            hold_data  <= 32'd0;
            err_q      <= 1'b0;
            last_addr  <= 5'd0;
            last_data  <= 32'd0;
        end else begin
            pending <= pend_nxt[31:1];
            if (issue_acc) wr_ptr <= wr_ptr + 1'b1;
            if (resp_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(issue_acc) - CNT_W'(resp_pop);

            // ld_resp_ready is low while holding, so a pop never lands on a full hold.
            if (alu_valid && resp_pop) begin
                hold_valid <= 1'b1;
                hold_rd    <= head_rd;
                hold_data  <= ld_resp_data;
            end else if (!alu_valid && hold_valid) begin
                hold_valid <= 1'b0;
            end

            if (drive) begin
                last_addr <= rf_addr;
                last_data <= rf_wdata;
            end

            if ((ld_issue && fifo_full) ||
                (resp_acc && fifo_empty) ||
                (alu_valid && alu_rd != 5'd0 && pend_full[alu_rd]))
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rd_valid;
    logic        stall, rf_write, err;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    regfile_wb_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_ready(ld_resp_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_valid(dec_rd_valid),
        .stall(stall), .rf_write(rf_write), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: a queue of outstanding load rds, a set of pending
    // registers, an optional parked load, the last value on the write port.
    bit          m_pend [32];
    logic [4:0]  m_ldq [$];
    bit          m_hold_v;
    logic [4:0]  m_hold_rd;
    logic [31:0] m_hold_d;
    bit          m_err;
    logic [4:0]  m_last_a;
    logic [31:0] m_last_d;

    bit          e_stall, e_w, e_ir, e_rr, e_err;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    bit          m_acc, m_pop, m_drive, m_done;
    logic [4:0]  m_head, m_done_rd;

    logic [36:0] exp_q [$];   // expected register-file write stream {addr, data}

    task automatic model_clear();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_ldq.delete();
        m_hold_v = 1'b0;
        m_err    = 1'b0;
        m_last_a = 5'd0;
        m_last_d = 32'd0;
    endtask

    function automatic bit hz(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r] && !(e_w && e_a == r);
    endfunction

    task automatic model_eval();
        if (rst) model_clear();
        e_ir   = !rst && (m_ldq.size() < DEPTH);
        e_rr   = !rst && !m_hold_v;
        m_acc  = ld_resp_valid && e_rr;
        m_pop  = m_acc && (m_ldq.size() > 0);
        m_head = (m_ldq.size() > 0) ? m_ldq[0] : 5'd0;
        m_drive = 1'b0; m_done = 1'b0; m_done_rd = 5'd0;
        e_w = 1'b0; e_a = m_last_a; e_d = m_last_d;
        if (alu_valid) begin
            m_drive = 1'b1; e_w = (alu_rd != 0); e_a = alu_rd; e_d = alu_data;
        end else if (m_hold_v) begin
            m_drive = 1'b1; m_done = 1'b1; m_done_rd = m_hold_rd;
            e_w = (m_hold_rd != 0); e_a = m_hold_rd; e_d = m_hold_d;
        end else if (m_pop) begin
            m_drive = 1'b1; m_done = 1'b1; m_done_rd = m_head;
            e_w = (m_head != 0); e_a = m_head; e_d = ld_resp_data;
        end
        if (rst) begin e_w = 1'b0; e_a = 5'd0; e_d = 32'd0; end
        e_stall = !rst && (hz(dec_rs1) || hz(dec_rs2) || (dec_rd_valid && hz(dec_rd)));
        e_err   = m_err;
    endtask

    task automatic model_commit();
        if (rst) begin model_clear(); return; end
        if (ld_issue && m_ldq.size() == DEPTH) m_err = 1'b1;
        if (m_acc && m_ldq.size() == 0) m_err = 1'b1;
        if (alu_valid && alu_rd != 0 && m_pend[alu_rd]) m_err = 1'b1;
        if (m_done && m_done_rd != 0) m_pend[m_done_rd] = 1'b0;
        if (m_drive) begin m_last_a = e_a; m_last_d = e_d; end
        if (alu_valid && m_pop) begin
            m_hold_v = 1'b1; m_hold_rd = m_head; m_hold_d = ld_resp_data;
        end else if (!alu_valid && m_hold_v) begin
            m_hold_v = 1'b0;
        end
        if (m_pop) void'(m_ldq.pop_front());
        if (ld_issue && e_ir) begin
            m_ldq.push_back(ld_issue_rd);
            if (ld_issue_rd != 0) m_pend[ld_issue_rd] = 1'b1;
        end
    endtask

    // ---------------- driver / scoreboard tasks ----------------
    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_resp_valid = 0; ld_resp_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_valid = 0;
    endtask

    // Called at posedge+1 with inputs applied; compares at the falling edge.
    task automatic settle_and_check();
        #4;
        model_eval();
        chk("stall", stall, e_stall);
        chk("rf_write", rf_write, e_w);
        chk("rf_addr", rf_addr, e_a);
        chk("rf_wdata", rf_wdata, e_d);
        chk("ld_issue_ready", ld_issue_ready, e_ir);
        chk("ld_resp_ready", ld_resp_ready, e_rr);
        chk("err", err, e_err);
        if (e_w) exp_q.push_back({e_a, e_d});
        if (rf_write === 1'b1) begin
            if (exp_q.size() == 0) chk("write_stream_extra", {27'd0, rf_addr}, 32'd0 - 1);
            else begin
                logic [36:0] ex;
                ex = exp_q.pop_front();
                chk("write_stream_addr", {27'd0, rf_addr}, {27'd0, ex[36:32]});
                chk("write_stream_data", rf_wdata, ex[31:0]);
            end
        end
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle_and_check();
        advance();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        li;
        logic [4:0]  lrd;
        logic        rv;
        logic [31:0] rdat;
        logic [4:0]  rs1, rs2, rd;
        logic        rdv;
        logic        x_stall, x_w;
        logic [4:0]  x_a;
        logic [31:0] x_d;
        logic        x_ir, x_rr, x_err;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        logic r, logic av, logic [4:0] ard, logic [31:0] adat, logic li, logic [4:0] lrd,
        logic rv, logic [31:0] rdat, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic rdv,
        logic xs, logic xw, logic [4:0] xa, logic [31:0] xd, logic xir, logic xrr, logic xe);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.adat = adat; v.li = li; v.lrd = lrd;
        v.rv = rv; v.rdat = rdat; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rdv = rdv;
        v.x_stall = xs; v.x_w = xw; v.x_a = xa; v.x_d = xd; v.x_ir = xir; v.x_rr = xrr; v.x_err = xe;
        return v;
    endfunction

    task automatic fill_table();
        //           rst av ard adat       li lrd rv rdat          rs1 rs2 rd rdv  stall w a  d             ir rr err
        tbl.push_back(mk(1, 0, 0, 0,         0, 0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 5, 0, 0,            5, 0, 0, 0,   0, 0, 0, 0,            1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            5, 0, 0, 0,   1, 0, 0, 0,            1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'hDEADBEEF, 5, 0, 0, 0,   0, 1, 5, 32'hDEADBEEF, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            5, 0, 0, 0,   0, 0, 5, 32'hDEADBEEF, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 7, 0, 0,            0, 0, 0, 0,   0, 0, 5, 32'hDEADBEEF, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3, 32'h11,    0, 0, 1, 32'h77,       7, 0, 0, 0,   1, 1, 3, 32'h11,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            7, 0, 0, 0,   0, 1, 7, 32'h77,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            7, 0, 0, 0,   0, 0, 7, 32'h77,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 1, 0, 0,            0, 0, 0, 0,   0, 0, 7, 32'h77,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 2, 0, 0,            0, 0, 0, 0,   0, 0, 7, 32'h77,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 3, 0, 0,            0, 0, 0, 0,   0, 0, 7, 32'h77,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 4, 0, 0,            0, 0, 0, 0,   0, 0, 7, 32'h77,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            0, 1, 0, 0,   1, 0, 7, 32'h77,       0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 6, 0, 0,            0, 0, 0, 0,   0, 0, 7, 32'h77,       0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'hA,        2, 0, 0, 0,   1, 1, 1, 32'hA,        0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'hB,        2, 0, 0, 0,   0, 1, 2, 32'hB,        1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'hC,        0, 0, 0, 0,   0, 1, 3, 32'hC,        1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'hD,        0, 0, 4, 1,   0, 1, 4, 32'hD,        1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            0, 0, 4, 1,   0, 0, 4, 32'hD,        1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0,         0, 0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 0, 0, 0,            0, 0, 0, 0,   0, 0, 0, 0,            1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'h55,       0, 0, 0, 1,   0, 0, 0, 32'h55,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 10, 0, 0,           0, 0, 0, 0,   0, 0, 0, 32'h55,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'h1010,     10, 0, 0, 0,  0, 1, 10, 32'h1010,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 9, 0, 0,            0, 0, 0, 0,   0, 0, 10, 32'h1010,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            9, 0, 0, 0,   1, 0, 10, 32'h1010,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         1, 9, 1, 32'h99,       9, 0, 0, 0,   0, 1, 9, 32'h99,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            9, 0, 0, 0,   1, 0, 9, 32'h99,       1, 1, 0));
        tbl.push_back(mk(0, 1, 9, 32'h1234,  0, 0, 0, 0,            9, 0, 0, 0,   0, 1, 9, 32'h1234,     1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            9, 0, 0, 0,   1, 0, 9, 32'h1234,     1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 1, 32'h9999,     0, 9, 0, 0,   0, 1, 9, 32'h9999,     1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,         0, 0, 0, 0,            9, 0, 0, 0,   0, 0, 9, 32'h9999,     1, 1, 1));
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        @(posedge clk);
        #1;

        fill_table();
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            ld_issue = tbl[i].li; ld_issue_rd = tbl[i].lrd;
            ld_resp_valid = tbl[i].rv; ld_resp_data = tbl[i].rdat;
            dec_rs1 = tbl[i].rs1; dec_rs2 = tbl[i].rs2; dec_rd = tbl[i].rd; dec_rd_valid = tbl[i].rdv;
            settle_and_check();
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].x_stall);
            chk($sformatf("tbl%0d_rf_write", i), rf_write, tbl[i].x_w);
            chk($sformatf("tbl%0d_rf_addr", i), rf_addr, tbl[i].x_a);
            chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].x_d);
            chk($sformatf("tbl%0d_ld_issue_ready", i), ld_issue_ready, tbl[i].x_ir);
            chk($sformatf("tbl%0d_ld_resp_ready", i), ld_resp_ready, tbl[i].x_rr);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].x_err);
            advance();
        end

        // Reset mid-stream: two loads outstanding and the hold buffer full.
        rst = 1'b1; idle_inputs(); cycle();
        rst = 1'b0;
        ld_issue = 1; ld_issue_rd = 11; cycle();
        ld_issue_rd = 12; cycle();
        idle_inputs();
        ld_issue = 1; ld_issue_rd = 13;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h5;
        ld_resp_valid = 1; ld_resp_data = 32'h1111;
        cycle();
        idle_inputs();
        alu_valid = 1; alu_rd = 2; alu_data = 32'h6; dec_rs1 = 12;
        #1;
        chk("midrst_pre_resp_ready", ld_resp_ready, 0);
        chk("midrst_pre_stall", stall, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rf_write", rf_write, 0);
        chk("midrst_rf_addr", rf_addr, 0);
        chk("midrst_rf_wdata", rf_wdata, 0);
        chk("midrst_resp_ready", ld_resp_ready, 0);
        chk("midrst_issue_ready", ld_issue_ready, 0);
        chk("midrst_stall", stall, 0);
        model_clear();
        settle_and_check();
        advance();
        rst = 1'b0;
        idle_inputs();
        dec_rs1 = 11; dec_rs2 = 12; dec_rd = 13; dec_rd_valid = 1;
        settle_and_check();
        chk("postrst_stall", stall, 0);
        chk("postrst_resp_ready", ld_resp_ready, 1);
        chk("postrst_issue_ready", ld_issue_ready, 1);
        chk("postrst_err", err, 0);
        chk("postrst_no_write", rf_write, 0);
        advance();
        idle_inputs();
        ld_resp_valid = 1; ld_resp_data = 32'hBAD;
        cycle();
        idle_inputs();
        settle_and_check();
        chk("postrst_stale_resp_err", err, 1);
        advance();

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            alu_valid     = ($urandom_range(0, 1) == 0);
            alu_rd        = 5'($urandom_range(0, 15));
            alu_data      = $urandom;
            ld_issue      = ($urandom_range(0, 4) < 2);
            ld_issue_rd   = 5'($urandom_range(0, 7));
            ld_resp_valid = ($urandom_range(0, 4) < 2);
            ld_resp_data  = $urandom;
            dec_rs1       = 5'($urandom_range(0, 9));
            dec_rs2       = 5'($urandom_range(0, 9));
            dec_rd        = 5'($urandom_range(0, 9));
            dec_rd_valid  = ($urandom_range(0, 1) == 0);
            cycle();
        end

        rst = 1'b0;
        idle_inputs();
        cycle();
        chk("write_stream_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
